// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Function : Fetch stage of the 8-bit core. It assembles 1- or 2-byte
//            instructions from a combinational 32-byte instruction memory and
//            hands each one to decode over a valid/ready handshake.
// Option   : FETCH_PERF_EN adds the saturating perf_issued transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [4:0]  RESET_PC      = 5'd0,
  parameter logic [15:0] TWO_BYTE_MASK = 16'h003C
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       fetch_en,
  input  logic       branch_taken,
  input  logic [4:0] branch_target,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic       instr_len2,
  output logic [4:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_issued
`endif
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic       valid_q, valid_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       len2_q, len2_d;
  logic [4:0] ipc_q, ipc_d;

  logic w_is2;
  logic w_xfer;
  logic w_latch_op;

  assign w_is2  = TWO_BYTE_MASK[imem_data[7:4]];
  assign w_xfer = valid_q & instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    len2_d     = len2_q;
    ipc_d      = ipc_q;
    w_latch_op = 1'b0;

    // A redirect wins over every fetch action; a concurrent transfer is
    // still consumed because valid simply drops.
    if (branch_taken) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (fetch_en) begin
            w_latch_op = 1'b1;
          end
        end
        FETCH_ARG: begin
          if (fetch_en) begin
            operand_d = imem_data;
            len2_d    = 1'b1;
            pc_d      = pc_q + 5'd1;
            valid_d   = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (w_xfer) begin
            if (fetch_en) begin
              w_latch_op = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = FETCH_OP;
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = FETCH_OP;
        end
      endcase
    end

    // Opcode capture is shared by FETCH_OP and the back-to-back path in HOLD.
    if (w_latch_op) begin
      opcode_d = imem_data;
      ipc_d    = pc_q;
      pc_d     = pc_q + 5'd1;
      if (w_is2) begin
        valid_d = 1'b0;
        state_d = FETCH_ARG;
      end else begin
        operand_d = 8'h00;
        len2_d    = 1'b0;
        valid_d   = 1'b1;
        state_d   = HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      len2_q    <= 1'b0;
      ipc_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len2_q    <= len2_d;
      ipc_q     <= ipc_d;
    end
  end

  assign imem_addr     = pc_q;
  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_len2    = len2_q;
  assign instr_pc      = ipc_q;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (w_xfer && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 16'h0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_issued = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, 1/2-byte assembly, stall,
// branch redirect, PC wrap and fetch freeze, with hand-computed expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic       fetch_en;
  logic       branch_taken;
  logic [4:0] branch_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_len2;
  logic [4:0] instr_pc;

  logic [7:0] mem [0:31];
  int compared   = 0;
  int mismatched = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .fetch_en      (fetch_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_len2    (instr_len2),
    .instr_pc      (instr_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full slot plus address: {valid, opcode, operand, len2, instr_pc, imem_addr}
  task automatic check_slot(input string tag, input logic v, input logic [7:0] op,
                            input logic [7:0] opd, input logic l2,
                            input logic [4:0] ipc, input logic [4:0] addr);
    logic [27:0] obs, exp;
    obs = {instr_valid, instr_opcode, instr_operand, instr_len2, instr_pc, imem_addr};
    exp = {v, op, opd, l2, ipc, addr};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed v=%b op=%h opd=%h len2=%b pc=%0d addr=%0d expected v=%b op=%h opd=%h len2=%b pc=%0d addr=%0d",
             tag, instr_valid, instr_opcode, instr_operand, instr_len2, instr_pc, imem_addr,
             v, op, opd, l2, ipc, addr);
    end
  endtask

  task automatic check_va(input string tag, input logic v, input logic [4:0] addr);
    logic [5:0] obs, exp;
    obs = {instr_valid, imem_addr};
    exp = {v, addr};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed valid=%b addr=%0d expected valid=%b addr=%0d",
             tag, instr_valid, imem_addr, v, addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h10;
    reset         = 1'b1;
    fetch_en      = 1'b0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 5'd0;

    // Reset state
    tick();
    tick();
    check_slot("reset_state", 1'b0, 8'h00, 8'h00, 1'b0, 5'd0, 5'd0);

    // 2-byte instruction at 0, then a 5-cycle stall
    mem[0] = 8'h3C;
    mem[1] = 8'h00;
    reset       = 1'b0;
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    tick();
    check_va("two_byte_first_edge", 1'b0, 5'd1);
    tick();
    check_slot("two_byte_done", 1'b1, 8'h3C, 8'h00, 1'b1, 5'd0, 5'd2);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_slot("stall_hold", 1'b1, 8'h3C, 8'h00, 1'b1, 5'd0, 5'd2);
    end
    instr_ready = 1'b1;
    tick();
    check_slot("after_stall_pc2", 1'b1, 8'h10, 8'h00, 1'b0, 5'd2, 5'd3);
    tick();
    check_slot("after_stall_pc3", 1'b1, 8'h10, 8'h00, 1'b0, 5'd3, 5'd4);

    // Back-to-back 1-byte stream, then branch during FETCH_ARG
    reset = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = 8'h10;
    mem[4] = 8'h20;
    mem[9] = 8'h11;
    tick();
    reset = 1'b0;
    tick();
    check_slot("stream_pc0", 1'b1, 8'h10, 8'h00, 1'b0, 5'd0, 5'd1);
    tick();
    check_slot("stream_pc1", 1'b1, 8'h10, 8'h00, 1'b0, 5'd1, 5'd2);
    tick();
    check_slot("stream_pc2", 1'b1, 8'h10, 8'h00, 1'b0, 5'd2, 5'd3);
    tick();
    check_slot("stream_pc3", 1'b1, 8'h10, 8'h00, 1'b0, 5'd3, 5'd4);
    tick();
    check_va("enter_fetch_arg", 1'b0, 5'd5);
    branch_taken  = 1'b1;
    branch_target = 5'd9;
    tick();
    check_va("branch_redirect", 1'b0, 5'd9);
    branch_taken = 1'b0;
    tick();
    check_slot("branch_refetch", 1'b1, 8'h11, 8'h00, 1'b0, 5'd9, 5'd10);

    // Asynchronous reset asserted mid-cycle
    #3;
    reset = 1'b1;
    #1;
    check_slot("async_reset", 1'b0, 8'h00, 8'h00, 1'b0, 5'd0, 5'd0);
    tick();
    reset = 1'b0;

    // PC wrap: 2-byte opcode at 31, operand from 0
    mem[31] = 8'h2A;
    mem[0]  = 8'h5B;
    mem[1]  = 8'h10;
    fetch_en      = 1'b1;
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 5'd31;
    tick();
    check_va("branch_to_31", 1'b0, 5'd31);
    branch_taken = 1'b0;
    tick();
    check_va("wrap_opcode", 1'b0, 5'd0);
    tick();
    check_slot("wrap_done", 1'b1, 8'h2A, 8'h5B, 1'b1, 5'd31, 5'd1);

    // Transfer with fetch frozen, then resume
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    tick();
    check_va("xfer_frozen", 1'b0, 5'd1);
    tick();
    check_va("still_frozen", 1'b0, 5'd1);
    fetch_en = 1'b1;
    tick();
    check_slot("resume_fetch", 1'b1, 8'h10, 8'h00, 1'b0, 5'd1, 5'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
